// File: rtl/cgra_pipe_pkg.sv
// Shared types and encodings for the ID/EX pipeline slice: opcodes, ALU op classes,
// the decoder control bundle and the ID/EX FSM state.
package cgra_pipe_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_VEC    = 7'b1010111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_ITYPE  = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       imm_select;
    } ctrl_t;

    typedef enum logic {StRun, StVecWait} state_e;

    // A bubble keeps operand-select bits but drops every side-effecting control.
    function automatic ctrl_t bubble_ctrl(ctrl_t c);
        ctrl_t b;
        b            = '0;
        b.alu_op     = ALU_ADD;
        b.alu_src    = c.alu_src;
        b.imm_select = c.imm_select;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Combinational load-use detector: a load in EX whose destination feeds the ID instruction.
module id_ex_hazard
    import cgra_pipe_pkg::*;
(
    input  logic       id_valid_i,
    input  logic       ex_valid_i,
    input  logic       ex_mem_rd_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic       alu_src_i,
    input  logic       mem_wr_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = (ex_rd_addr_i == rs1_addr_i);
    // rs2 is only read when it is the ALU operand or the store data.
    assign rs2_hit = (ex_rd_addr_i == rs2_addr_i) && (!alu_src_i || mem_wr_i);

    assign load_use_o = id_valid_i && ex_valid_i && ex_mem_rd_i && (ex_rd_addr_i != 5'd0) &&
                        (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, flush and CGRA vector-op hold.
// Optional macro VEC_TIMEOUT_EN bounds the vector wait and raises vec_err_o on expiry.
module id_ex_stage
    import cgra_pipe_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned VEC_TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [1:0]      ALUOp_i,
    input  logic            ALUSrc_i,
    input  logic            RegWrite_i,
    input  logic            MemRd_i,
    input  logic            MemWr_i,
    input  logic            MemToReg_i,
    input  logic            immSelect_i,
    input  logic            vec_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [9:0]      funct_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    input  logic            vec_ack_i,
    output logic            ex_valid_o,
    output logic            ex_vec_o,
    output logic [1:0]      ex_ALUOp_o,
    output logic            ex_ALUSrc_o,
    output logic            ex_RegWrite_o,
    output logic            ex_MemRd_o,
    output logic            ex_MemWr_o,
    output logic            ex_MemToReg_o,
    output logic            ex_immSelect_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rs1_data_o,
    output logic [XLEN-1:0] ex_rs2_data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [9:0]      ex_funct_o,
    output logic [4:0]      ex_rs1_addr_o,
    output logic [4:0]      ex_rs2_addr_o,
    output logic [4:0]      ex_rd_addr_o,
    output logic            stall_o,
    output logic            vec_req_o,
    output logic            vec_err_o
);

    state_e          state_q, state_d;
    ctrl_t           ctrl_q, ctrl_d, id_ctrl;
    logic            valid_q, valid_d, vec_q, vec_d, req_q, req_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    logic [9:0]      funct_q, funct_d;
    logic [4:0]      a1_q, a1_d, a2_q, a2_d, rd_q, rd_d;
    logic            load_use, accept, squash, timeout;

    assign id_ctrl = '{alu_op: ALUOp_i, alu_src: ALUSrc_i, reg_write: RegWrite_i,
                       mem_rd: MemRd_i, mem_wr: MemWr_i, mem_to_reg: MemToReg_i,
                       imm_select: immSelect_i};

    id_ex_hazard u_hazard (
        .id_valid_i  (id_valid_i),
        .ex_valid_i  (valid_q),
        .ex_mem_rd_i (ctrl_q.mem_rd),
        .ex_rd_addr_i(rd_q),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .alu_src_i   (ALUSrc_i),
        .mem_wr_i    (MemWr_i),
        .load_use_o  (load_use)
    );

    assign stall_o = load_use || ((state_q == StVecWait) && !vec_ack_i);
    assign accept  = (state_q == StRun) || vec_ack_i;
    // Flush is meaningless while a vector op occupies EX, so it only squashes in RUN.
    assign squash  = timeout || load_use || (flush_i && (state_q == StRun));

`ifdef VEC_TIMEOUT_EN
    localparam int unsigned CntW = (VEC_TIMEOUT > 255) ? $clog2(VEC_TIMEOUT + 1) : 8;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q;

    assign timeout   = (state_q == StVecWait) && !vec_ack_i &&
                       (cnt_q == CntW'(VEC_TIMEOUT - 1));
    assign cnt_d     = ((state_q == StVecWait) && !vec_ack_i) ? cnt_q + 1'b1 : '0;
    assign vec_err_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= timeout;
        end
    end
`else
    assign timeout   = 1'b0;
    assign vec_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        vec_d   = vec_q;
        req_d   = req_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        funct_d = funct_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        rd_d    = rd_q;
        if (accept || timeout) begin
            pc_d    = pc_i;
            rs1_d   = rs1_data_i;
            rs2_d   = rs2_data_i;
            imm_d   = imm_i;
            funct_d = funct_i;
            a1_d    = rs1_addr_i;
            a2_d    = rs2_addr_i;
            rd_d    = rd_addr_i;
            ctrl_d  = bubble_ctrl(id_ctrl);
            valid_d = 1'b0;
            vec_d   = 1'b0;
            state_d = StRun;
            req_d   = 1'b0;
            if (!squash) begin
                ctrl_d  = id_ctrl;
                valid_d = id_valid_i;
                vec_d   = vec_i && id_valid_i;
                if (vec_i && id_valid_i) begin
                    state_d = StVecWait;
                    req_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            vec_q   <= 1'b0;
            req_q   <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            funct_q <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            vec_q   <= vec_d;
            req_q   <= req_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            funct_q <= funct_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            rd_q    <= rd_d;
        end
    end

    assign ex_valid_o     = valid_q;
    assign ex_vec_o       = vec_q;
    assign ex_ALUOp_o     = ctrl_q.alu_op;
    assign ex_ALUSrc_o    = ctrl_q.alu_src;
    assign ex_RegWrite_o  = ctrl_q.reg_write;
    assign ex_MemRd_o     = ctrl_q.mem_rd;
    assign ex_MemWr_o     = ctrl_q.mem_wr;
    assign ex_MemToReg_o  = ctrl_q.mem_to_reg;
    assign ex_immSelect_o = ctrl_q.imm_select;
    assign ex_pc_o        = pc_q;
    assign ex_rs1_data_o  = rs1_q;
    assign ex_rs2_data_o  = rs2_q;
    assign ex_imm_o       = imm_q;
    assign ex_funct_o     = funct_q;
    assign ex_rs1_addr_o  = a1_q;
    assign ex_rs2_addr_o  = a2_q;
    assign ex_rd_addr_o   = rd_q;
    assign vec_req_o      = req_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the stage.
module tb_id_ex_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned VEC_TO = 8;
`ifdef VEC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic        vec;
        logic [1:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_rd;
        logic        mem_wr;
        logic        mem_to_reg;
        logic        imm_sel;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 1'b0, alu_src = 1'b0, reg_write = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
    logic mem_to_reg = 1'b0, imm_sel = 1'b0, vec = 1'b0, flush = 1'b0, ack = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [31:0] pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
    logic [9:0]  funct = '0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;

    logic ex_valid, ex_vec, ex_alusrc, ex_regwrite, ex_memrd, ex_memwr, ex_memtoreg, ex_immsel;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic [9:0]  ex_funct;
    logic [4:0]  ex_a1, ex_a2, ex_rd;
    logic stall, vec_req, vec_err;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_stage #(.XLEN(XLEN), .VEC_TIMEOUT(VEC_TO)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .ALUOp_i(alu_op),
        .ALUSrc_i(alu_src), .RegWrite_i(reg_write), .MemRd_i(mem_rd), .MemWr_i(mem_wr),
        .MemToReg_i(mem_to_reg), .immSelect_i(imm_sel), .vec_i(vec), .pc_i(pc),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm), .funct_i(funct),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr), .flush_i(flush),
        .vec_ack_i(ack), .ex_valid_o(ex_valid), .ex_vec_o(ex_vec), .ex_ALUOp_o(ex_aluop),
        .ex_ALUSrc_o(ex_alusrc), .ex_RegWrite_o(ex_regwrite), .ex_MemRd_o(ex_memrd),
        .ex_MemWr_o(ex_memwr), .ex_MemToReg_o(ex_memtoreg), .ex_immSelect_o(ex_immsel),
        .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1), .ex_rs2_data_o(ex_rs2), .ex_imm_o(ex_imm),
        .ex_funct_o(ex_funct), .ex_rs1_addr_o(ex_a1), .ex_rs2_addr_o(ex_a2),
        .ex_rd_addr_o(ex_rd), .stall_o(stall), .vec_req_o(vec_req), .vec_err_o(vec_err)
    );

    always #5 clk = ~clk;

    ex_t dut_ex;
    assign dut_ex = '{valid: ex_valid, vec: ex_vec, alu_op: ex_aluop, alu_src: ex_alusrc,
                      reg_write: ex_regwrite, mem_rd: ex_memrd, mem_wr: ex_memwr,
                      mem_to_reg: ex_memtoreg, imm_sel: ex_immsel, pc: ex_pc, rs1: ex_rs1,
                      rs2: ex_rs2, imm: ex_imm, funct: ex_funct, a1: ex_a1, a2: ex_a2,
                      rd: ex_rd};

    // Reference model: what instruction sits in EX, whether it is a vector op still
    // owned by the CGRA, and how many cycles it has been waiting.
    ex_t m_ex;
    bit  m_busy;
    int  m_waited;
    bit  m_err;
    bit  exp_stall;
    logic obs_stall;

    function automatic bit model_hazard();
        bit reads_rd;
        reads_rd = (m_ex.rd == rs1_addr) || ((m_ex.rd == rs2_addr) && (!alu_src || mem_wr));
        return id_valid && m_ex.valid && m_ex.mem_rd && (m_ex.rd != 5'd0) && reads_rd;
    endfunction

    task automatic model_reset();
        m_ex = '0; m_busy = 0; m_waited = 0; m_err = 0;
    endtask

    // Advance one clock: sample stall before the edge, update the model, land at edge+1.
    task automatic tick();
        bit hz, moves, expired, kill;
        #3;
        obs_stall = stall;
        hz        = model_hazard();
        exp_stall = hz || (m_busy && !ack);
        if (rst) begin
            model_reset();
        end else begin
            moves   = !m_busy || ack;
            expired = TO_EN && m_busy && !ack && (m_waited + 1 == VEC_TO);
            m_err   = expired;
            if (moves || expired) begin
                kill = expired || hz || (!m_busy && flush);
                m_ex.pc = pc; m_ex.rs1 = rs1_data; m_ex.rs2 = rs2_data; m_ex.imm = imm;
                m_ex.funct = funct; m_ex.a1 = rs1_addr; m_ex.a2 = rs2_addr; m_ex.rd = rd_addr;
                m_ex.alu_src = alu_src; m_ex.imm_sel = imm_sel;
                if (kill) begin
                    m_ex.valid = 0; m_ex.vec = 0; m_ex.alu_op = 2'b00; m_ex.reg_write = 0;
                    m_ex.mem_rd = 0; m_ex.mem_wr = 0; m_ex.mem_to_reg = 0;
                end else begin
                    m_ex.valid = id_valid; m_ex.vec = vec && id_valid; m_ex.alu_op = alu_op;
                    m_ex.reg_write = reg_write; m_ex.mem_rd = mem_rd; m_ex.mem_wr = mem_wr;
                    m_ex.mem_to_reg = mem_to_reg;
                end
                m_busy   = !kill && id_valid && vec;
                m_waited = 0;
            end else begin
                m_waited++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input bit v, input bit is_vec, input bit ld, input bit st,
                               input bit isrc, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd);
        id_valid = v; vec = is_vec; mem_rd = ld; mem_wr = st; alu_src = isrc;
        mem_to_reg = ld; reg_write = !st && !is_vec; imm_sel = isrc;
        alu_op = isrc ? 2'b11 : 2'b10;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
        pc = $urandom; rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
        funct = 10'($urandom);
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; ack = 0;
        drive_instr(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        n_checks++;
        if ({dut_ex, vec_req, vec_err, stall} !== '0)
            $display("FAIL reset_outputs: got %h, want 0", {dut_ex, vec_req, vec_err, stall});
        else n_pass++;
        tick();
        rst = 0;
    endtask

    task automatic test_load_use();
        drive_instr(1, 0, 1, 0, 1, 5'd2, 5'd0, 5'd5);
        tick();
        n_checks++;
        if (!(ex_valid === 1'b1 && ex_memrd === 1'b1 && ex_rd === 5'd5))
            $display("FAIL lw_in_ex: valid=%b memrd=%b rd=%0d, want 1 1 5",
                     ex_valid, ex_memrd, ex_rd);
        else n_pass++;
        drive_instr(1, 0, 0, 0, 0, 5'd5, 5'd6, 5'd7);
        #1;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL load_use_stall: got %b, want 1", stall);
        else n_pass++;
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0)
            $display("FAIL load_use_bubble: valid=%b regwrite=%b, want 0 0",
                     ex_valid, ex_regwrite);
        else n_pass++;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL load_use_release: got %b, want 0", stall);
        else n_pass++;
        tick();
        n_checks++;
        if (!(ex_valid === 1'b1 && ex_a1 === 5'd5 && ex_rd === 5'd7 && ex_regwrite === 1'b1))
            $display("FAIL load_use_add_in_ex: valid=%b rs1=%0d rd=%0d, want 1 5 7",
                     ex_valid, ex_a1, ex_rd);
        else n_pass++;
    endtask

    task automatic test_rd_zero();
        drive_instr(1, 0, 1, 0, 1, 5'd3, 5'd0, 5'd0);
        tick();
        drive_instr(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd9);
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL rd_zero_stall: got %b, want 0", stall);
        else n_pass++;
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd9)
            $display("FAIL rd_zero_no_bubble: valid=%b rd=%0d, want 1 9", ex_valid, ex_rd);
        else n_pass++;
    endtask

    task automatic test_vector();
        int req_cycles = 0, stall_cycles = 0;
        drive_instr(1, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        tick();
        n_checks++;
        if (ex_vec !== 1'b1 || ex_valid !== 1'b1)
            $display("FAIL vec_load: vec=%b valid=%b, want 1 1", ex_vec, ex_valid);
        else n_pass++;
        drive_instr(1, 0, 0, 0, 1, 5'd4, 5'd0, 5'd12);
        for (int i = 0; i < 5; i++) begin
            ack = (i == 4);
            #1;
            req_cycles   += int'(vec_req);
            stall_cycles += int'(stall);
            tick();
        end
        ack = 0;
        req_cycles += int'(vec_req);
        n_checks++;
        if (req_cycles != 5) $display("FAIL vec_req_cycles: got %0d, want 5", req_cycles);
        else n_pass++;
        n_checks++;
        if (stall_cycles != 4) $display("FAIL vec_stall_cycles: got %0d, want 4", stall_cycles);
        else n_pass++;
        n_checks++;
        if (!(ex_valid === 1'b1 && ex_vec === 1'b0 && ex_rd === 5'd12))
            $display("FAIL vec_next_instr: valid=%b vec=%b rd=%0d, want 1 0 12",
                     ex_valid, ex_vec, ex_rd);
        else n_pass++;
    endtask

    task automatic test_flush();
        drive_instr(1, 0, 0, 0, 1, 5'd1, 5'd0, 5'd8);
        flush = 1;
        tick();
        flush = 0;
        n_checks++;
        if (!(ex_valid === 1'b0 && ex_regwrite === 1'b0 && ex_rd === 5'd8))
            $display("FAIL flush_bubble: valid=%b regwrite=%b rd=%0d, want 0 0 8",
                     ex_valid, ex_regwrite, ex_rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid_vec();
        drive_instr(1, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        tick();
        drive_instr(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1;
        #1;
        n_checks++;
        if ({dut_ex, vec_req, stall} !== '0)
            $display("FAIL reset_mid_vec: got %h, want 0", {dut_ex, vec_req, stall});
        else n_pass++;
        tick();
        rst = 0;
        drive_instr(1, 0, 0, 0, 1, 5'd1, 5'd0, 5'd6);
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL run_after_reset_stall: got %b, want 0", stall);
        else n_pass++;
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || vec_req !== 1'b0)
            $display("FAIL run_after_reset: valid=%b req=%b, want 1 0", ex_valid, vec_req);
        else n_pass++;
    endtask

    task automatic test_timeout();
        drive_instr(1, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        tick();
        drive_instr(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < VEC_TO; i++) begin
            n_checks++;
            if (vec_err !== 1'b0 || vec_req !== 1'b1)
                $display("FAIL timeout_wait_%0d: err=%b req=%b, want 0 1", i, vec_err, vec_req);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (!(vec_err === 1'b1 && vec_req === 1'b0 && ex_valid === 1'b0 && ex_vec === 1'b0))
            $display("FAIL timeout_fire: err=%b req=%b valid=%b vec=%b, want 1 0 0 0",
                     vec_err, vec_req, ex_valid, ex_vec);
        else n_pass++;
        tick();
        n_checks++;
        if (vec_err !== 1'b0) $display("FAIL timeout_pulse_width: got %b, want 0", vec_err);
        else n_pass++;
        drive_instr(1, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        tick();
        drive_instr(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < VEC_TO - 1; i++) tick();
        ack = 1;
        tick();
        ack = 0;
        n_checks++;
        if (vec_err !== 1'b0 || vec_req !== 1'b0)
            $display("FAIL timeout_ack_wins: err=%b req=%b, want 0 0", vec_err, vec_req);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            drive_instr($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                        $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                        1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)));
            alu_op     = 2'($urandom);
            reg_write  = 1'($urandom);
            mem_to_reg = 1'($urandom);
            imm_sel    = 1'($urandom);
            flush      = $urandom_range(0, 6) == 0;
            ack        = $urandom_range(0, 3) == 0;
            tick();
            n_checks++;
            if (obs_stall !== exp_stall)
                $display("FAIL rnd_stall c%0d: got %b, want %b", c, obs_stall, exp_stall);
            else n_pass++;
            n_checks++;
            if (dut_ex !== m_ex)
                $display("FAIL rnd_ex c%0d: got %h, want %h", c, dut_ex, m_ex);
            else n_pass++;
            n_checks++;
            if (vec_req !== m_busy || vec_err !== m_err)
                $display("FAIL rnd_vec c%0d: req=%b err=%b, want %b %b",
                         c, vec_req, vec_err, m_busy, m_err);
            else n_pass++;
        end
        flush = 0;
        ack   = 0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_rd_zero();
        test_vector();
        test_flush();
        test_reset_mid_vec();
        if (TO_EN) test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the RISC-V core, directly downstream of the opcode decoder.
- Latches the decoder's control bundle with operands and register addresses, and detects load-use hazards.
- Inserts bubbles on hazard or branch flush.
- Holds vector-opcode (1010111) instructions in EX until the CGRA acknowledges completion, stalling the front end meanwhile.

Parameters:
- XLEN, 32, operand/PC/immediate width
- VEC_TIMEOUT, 255, max cycles waiting for vec_ack_i (used only with VEC_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- id_valid_i  in  1  ID holds a valid instruction
- ALUOp_i  in  2  decoder ALU op class
- ALUSrc_i, RegWrite_i, MemRd_i, MemWr_i, MemToReg_i, immSelect_i  in  1 each  decoder controls
- vec_i  in  1  ID instruction is a vector op
- pc_i, rs1_data_i, rs2_data_i, imm_i  in  XLEN each  ID operands
- funct_i  in  10  {funct7, funct3}
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  register indices
- flush_i  in  1  branch taken in EX; squash the ID instruction
- vec_ack_i  in  1  CGRA finished the held vector op
- ex_valid_o, ex_vec_o  out  1 each  registered valid / vector flag
- ex_ALUOp_o  out  2;  ex_ALUSrc_o, ex_RegWrite_o, ex_MemRd_o, ex_MemWr_o, ex_MemToReg_o, ex_immSelect_o  out  1 each
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN
- ex_funct_o  out  10;  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  5
- stall_o  out  1  freeze PC and IF/ID (combinational)
- vec_req_o  out  1  vector op in EX awaiting CGRA (registered)
- vec_err_o  out  1  vector timeout pulse (0 without VEC_TIMEOUT_EN)

Behaviour:
- Reset (async, rst_i=1): all ex_* outputs 0, vec_req_o=0, vec_err_o=0, state RUN.
- FSM states RUN and VEC_WAIT.
- load_use = id_valid_i & ex_valid_o & ex_MemRd_o & ex_rd_addr_o!=0 & (ex_rd_addr_o==rs1_addr_i | (ex_rd_addr_o==rs2_addr_i & !ALUSrc_i | MemWr_i)).
- stall_o = load_use | (state==VEC_WAIT & !vec_ack_i).
- Bubble:
  - ex_valid_o, ex_vec_o, ex_RegWrite_o, ex_MemRd_o, ex_MemWr_o, ex_MemToReg_o = 0; ex_ALUOp_o=00.
  - Data/address fields still load from ID.
- RUN, per-edge priority:
  1. flush_i → bubble.
  2. load_use → bubble; ID held by stall_o.
  3. Otherwise load all fields; ex_valid_o=id_valid_i, ex_vec_o=vec_i&id_valid_i.
- RUN exit: if a valid, non-flushed vector op loads, go to VEC_WAIT and set vec_req_o=1 the same edge.
- VEC_WAIT:
  - EX register holds; flush_i ignored (no branch can be in EX).
  - On vec_ack_i: stall_o=0 that cycle; at the edge EX loads the ID instruction under RUN rules, vec_req_o clears (or re-sets if a back-to-back vector op loads), state follows.
- vec_ack_i in RUN is ignored.
- Latency: one cycle ID→EX. Vector op occupies EX for 1 + (cycles until ack).
- Reset mid-VEC_WAIT: immediate return to RUN, vec_req_o=0; CGRA must tolerate request withdrawal.

Optional Feature:
- Macro VEC_TIMEOUT_EN.
- Defined:
  - 8-bit-min counter cleared on VEC_WAIT entry, increments each VEC_WAIT cycle.
  - At count==VEC_TIMEOUT without ack: vec_err_o pulses 1 cycle, EX becomes bubble, state→RUN, vec_req_o=0.
  - Ack on the same cycle as timeout wins (no error).
- Undefined: no counter; vec_err_o tied 0; VEC_WAIT unbounded.

Decomposition:
- Package cgra_pipe_pkg:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_VEC=7'b1010111)
  - ALUOp encodings (00 add, 01 branch, 10 R-type, 11 I-type)
  - ctrl bundle struct
  - state enum
- One sub-module, id_ex_hazard: combinational load-use detector producing load_use.

Test Plan:
- lw x5 in EX (MemRd=1, rd=5), ID add rs1=5 → stall_o=1, next cycle ex_valid_o=0; following cycle add loads into EX.
- lw rd=0 in EX, ID rs1=0 → stall_o=0, no bubble.
- Vector op loads; vec_ack_i after 4 cycles → vec_req_o high 5 cycles, stall_o high 4 cycles, next instruction in EX the cycle after ack.
- flush_i=1 with valid addi in ID → EX next cycle ex_valid_o=0, ex_RegWrite_o=0.
- rst_i asserted mid-VEC_WAIT → all outputs 0 asynchronously; RUN after release.
- With VEC_TIMEOUT_EN, VEC_TIMEOUT=8, no ack → vec_err_o single pulse at 8th wait cycle, vec_req_o=0, bubble in EX.
